pin_route_cfg: RTL and testbench

Configuration controller for the device pin bank (29 bidirectional pins). Host writes signal-to-pin routing entries into a staging table, then issues a commit. Commit scans the staging table for drive conflicts and, if clean, atomically swaps it into the active table. The active table drives the per-pin output enables and per-signal pin selects consumed by the pin mux in device.

---
 rtl/pin_route_pkg.sv | 25 ++
 rtl/pin_route_cfg_if.sv | 30 +++
 rtl/pin_route_check.sv | 39 +++
 rtl/pin_route_cfg.sv | 127 ++++++++++++
 tb/tb_pin_route_cfg.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pin_route_pkg.sv
// Shared constants and types for the pin bank routing controller.
//   NUM_PINS/PIN_W : device pin count and pin index width
//   NUM_SIG/SIG_W  : routable signal count and signal index width
//   state_t        : commit sequencer states
//   route_entry_t  : one signal-to-pin routing entry
package pin_route_pkg;

    localparam int unsigned NUM_PINS = 29;
    localparam int unsigned PIN_W    = 5;
    localparam int unsigned NUM_SIG  = 4;
    localparam int unsigned SIG_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        APPLY = 2'd2
    } state_t;

    typedef struct packed {
        logic             en;
        logic             dir;   // 1 = signal drives pin
        logic [PIN_W-1:0] pin;
    } route_entry_t;

endpackage

// File: rtl/pin_route_cfg_if.sv
// Host-side configuration bus: staging writes plus commit request/status.
//   master : host (drives cfg_* write fields and commit)
//   slave  : pin_route_cfg (drives ready, busy, done/err pulses, error report)
interface pin_route_cfg_if;
    import pin_route_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [SIG_W-1:0] cfg_sig;
    logic [PIN_W-1:0] cfg_pin;
    logic             cfg_dir;
    logic             cfg_en;
    logic             commit;
    logic             commit_busy;
    logic             commit_done;
    logic             commit_err;
    logic [SIG_W-1:0] err_sig;
    logic [PIN_W-1:0] err_pin;

    modport master (
        output cfg_valid, cfg_sig, cfg_pin, cfg_dir, cfg_en, commit,
        input  cfg_ready, commit_busy, commit_done, commit_err, err_sig, err_pin
    );

    modport slave (
        input  cfg_valid, cfg_sig, cfg_pin, cfg_dir, cfg_en, commit,
        output cfg_ready, commit_busy, commit_done, commit_err, err_sig, err_pin
    );

endinterface

// File: rtl/pin_route_check.sv
// Single-entry drive conflict test against the pins already claimed in a scan.
//   entry         : staging entry under test
//   claim_any     : pins claimed by any earlier entry
//   claim_out     : pins claimed by an earlier output entry
//   err           : entry is illegal (out-of-range pin or drive conflict)
//   claim_any_nxt : claim_any including this entry (equals claim_any on err)
//   claim_out_nxt : claim_out including this entry (equals claim_out on err)
module pin_route_check
    import pin_route_pkg::*;
(
    input  route_entry_t        entry,
    input  logic [NUM_PINS-1:0] claim_any,
    input  logic [NUM_PINS-1:0] claim_out,
    output logic                err,
    output logic [NUM_PINS-1:0] claim_any_nxt,
    output logic [NUM_PINS-1:0] claim_out_nxt
);

    // Outputs conflict with anything on the pin; inputs only with a driver,
    // so several inputs sharing a pin are legal fan-out.
    always_comb begin
        err           = 1'b0;
        claim_any_nxt = claim_any;
        claim_out_nxt = claim_out;
        if (entry.en) begin
            if (entry.pin >= PIN_W'(NUM_PINS)) begin
                err = 1'b1;
            end else if (entry.dir ? claim_any[entry.pin] : claim_out[entry.pin]) begin
                err = 1'b1;
            end else begin
                claim_any_nxt[entry.pin] = 1'b1;
                if (entry.dir) begin
                    claim_out_nxt[entry.pin] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pin_route_cfg.sv
// Pin bank routing controller: staging table written by the host, scanned for
// drive conflicts on commit and swapped atomically into the active table.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   cfg          : host configuration bus (slave side)
//   sig_en       : active enable per signal
//   sig_dir      : active direction per signal
//   sig_pin      : active pin per signal, entry i at [i*PIN_W +: PIN_W]
//   pin_oe       : per-pin output enable
module pin_route_cfg
    import pin_route_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    pin_route_cfg_if.slave           cfg,
    output logic [NUM_SIG-1:0]       sig_en,
    output logic [NUM_SIG-1:0]       sig_dir,
    output logic [NUM_SIG*PIN_W-1:0] sig_pin,
    output logic [NUM_PINS-1:0]      pin_oe
);

    state_t              state;
    logic [SIG_W-1:0]    idx;
    logic [NUM_PINS-1:0] claim_any;
    logic [NUM_PINS-1:0] claim_out;
    route_entry_t        staging [NUM_SIG];
    route_entry_t        active  [NUM_SIG];

    logic                chk_err;
    logic [NUM_PINS-1:0] claim_any_nxt;
    logic [NUM_PINS-1:0] claim_out_nxt;

    pin_route_check u_check (
        .entry         (staging[idx]),
        .claim_any     (claim_any),
        .claim_out     (claim_out),
        .err           (chk_err),
        .claim_any_nxt (claim_any_nxt),
        .claim_out_nxt (claim_out_nxt)
    );

    // Sequencer, tables and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            claim_any       <= '0;
            claim_out       <= '0;
            pin_oe          <= '0;
            cfg.cfg_ready   <= 1'b0;
            cfg.commit_busy <= 1'b0;
            cfg.commit_done <= 1'b0;
            cfg.commit_err  <= 1'b0;
            cfg.err_sig     <= '0;
            cfg.err_pin     <= '0;
            for (int i = 0; i < NUM_SIG; i++) begin
                staging[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            cfg.commit_done <= 1'b0;
            cfg.commit_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A write on the commit edge lands before entry 0 is read.
                    if (cfg.cfg_valid && cfg.cfg_ready) begin
                        staging[cfg.cfg_sig] <= '{en: cfg.cfg_en, dir: cfg.cfg_dir, pin: cfg.cfg_pin};
                    end
                    if (cfg.commit) begin
                        state           <= CHECK;
                        idx             <= '0;
                        claim_any       <= '0;
                        claim_out       <= '0;
                        cfg.cfg_ready   <= 1'b0;
                        cfg.commit_busy <= 1'b1;
                    end else begin
                        cfg.cfg_ready   <= 1'b1;
                    end
                end
                CHECK: begin
                    if (chk_err) begin
                        state           <= IDLE;
                        cfg.commit_err  <= 1'b1;
                        cfg.err_sig     <= idx;
                        cfg.err_pin     <= staging[idx].pin;
                        cfg.cfg_ready   <= 1'b1;
                        cfg.commit_busy <= 1'b0;
                    end else begin
                        claim_any <= claim_any_nxt;
                        claim_out <= claim_out_nxt;
                        if (idx == SIG_W'(NUM_SIG - 1)) begin
                            state <= APPLY;
                        end else begin
                            idx <= idx + SIG_W'(1);
                        end
                    end
                end
                APPLY: begin
                    // Table, pin enables and done pulse all change on one edge.
                    for (int i = 0; i < NUM_SIG; i++) begin
                        active[i] <= staging[i];
                    end
                    pin_oe          <= claim_out;
                    state           <= IDLE;
                    cfg.commit_done <= 1'b1;
                    cfg.cfg_ready   <= 1'b1;
                    cfg.commit_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flatten the active table onto the per-signal outputs.
    always_comb begin
        sig_en  = '0;
        sig_dir = '0;
        sig_pin = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            sig_en[i]                 = active[i].en;
            sig_dir[i]                = active[i].dir;
            sig_pin[i*PIN_W +: PIN_W] = active[i].pin;
        end
    end

endmodule

// File: tb/tb_pin_route_cfg.sv
// Self-checking bench for pin_route_cfg: directed scenarios followed by random
// staging/commit rounds, compared against a table-level reference model.
module tb_pin_route_cfg;
    import pin_route_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NUM_SIG-1:0]       sig_en;
    logic [NUM_SIG-1:0]       sig_dir;
    logic [NUM_SIG*PIN_W-1:0] sig_pin;
    logic [NUM_PINS-1:0]      pin_oe;

    int errors = 0;
    int checks = 0;

    // Reference model: staging (m_*), active (a_*), pin enables, error report.
    logic             m_en  [NUM_SIG];
    logic             m_dir [NUM_SIG];
    logic [PIN_W-1:0] m_pin [NUM_SIG];
    logic             a_en  [NUM_SIG];
    logic             a_dir [NUM_SIG];
    logic [PIN_W-1:0] a_pin [NUM_SIG];
    logic [NUM_PINS-1:0] a_oe;
    logic [SIG_W-1:0]    a_err_sig;
    logic [PIN_W-1:0]    a_err_pin;

    pin_route_cfg_if bus ();

    pin_route_cfg dut (
        .clock   (clock),
        .reset   (reset),
        .cfg     (bus),
        .sig_en  (sig_en),
        .sig_dir (sig_dir),
        .sig_pin (sig_pin),
        .pin_oe  (pin_oe)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_SIG; i++) begin
            m_en[i] = 1'b0; m_dir[i] = 1'b0; m_pin[i] = '0;
            a_en[i] = 1'b0; a_dir[i] = 1'b0; a_pin[i] = '0;
        end
        a_oe = '0; a_err_sig = '0; a_err_pin = '0;
    endtask

    // First illegal enabled entry (or -1) and the resulting driven-pin set.
    task automatic model_eval(output int err_i, output logic [NUM_PINS-1:0] oe);
        bit bad;
        err_i = -1;
        oe    = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (!m_en[i]) continue;
            bad = (int'(m_pin[i]) >= int'(NUM_PINS));
            for (int j = 0; j < i; j++) begin
                if (m_en[j] && m_pin[j] == m_pin[i] && (m_dir[i] || m_dir[j])) bad = 1'b1;
            end
            if (bad) begin
                err_i = i;
                break;
            end
            if (m_dir[i]) oe[m_pin[i]] = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_SIG-1:0]       e;
        logic [NUM_SIG-1:0]       d;
        logic [NUM_SIG*PIN_W-1:0] p;
        for (int i = 0; i < NUM_SIG; i++) begin
            e[i] = a_en[i];
            d[i] = a_dir[i];
            p[i*PIN_W +: PIN_W] = a_pin[i];
        end
        chk({tag, ".sig_en"},  64'(sig_en),      64'(e));
        chk({tag, ".sig_dir"}, 64'(sig_dir),     64'(d));
        chk({tag, ".sig_pin"}, 64'(sig_pin),     64'(p));
        chk({tag, ".pin_oe"},  64'(pin_oe),      64'(a_oe));
        chk({tag, ".err_sig"}, 64'(bus.err_sig), 64'(a_err_sig));
        chk({tag, ".err_pin"}, 64'(bus.err_pin), 64'(a_err_pin));
    endtask

    task automatic cfg_write(input int s, input int p, input bit d, input bit e);
        chk("wr_ready", 64'(bus.cfg_ready), 64'd1);
        bus.cfg_sig   = SIG_W'(s);
        bus.cfg_pin   = PIN_W'(p);
        bus.cfg_dir   = d;
        bus.cfg_en    = e;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        m_en[s] = e; m_dir[s] = d; m_pin[s] = PIN_W'(p);
    endtask

    // Commit (optionally with a write on the same edge); poke drives a second
    // commit and a write during the first scan cycle, both of which must be ignored.
    task automatic commit_and_check(input bit wr, input int s, input int p, input bit d,
                                    input bit e, input bit poke);
        int err_i;
        int lat;
        logic [NUM_PINS-1:0] oe;
        if (wr) begin
            bus.cfg_sig   = SIG_W'(s);
            bus.cfg_pin   = PIN_W'(p);
            bus.cfg_dir   = d;
            bus.cfg_en    = e;
            bus.cfg_valid = 1'b1;
            m_en[s] = e; m_dir[s] = d; m_pin[s] = PIN_W'(p);
        end
        model_eval(err_i, oe);
        bus.commit = 1'b1;
        step();
        bus.commit    = 1'b0;
        bus.cfg_valid = 1'b0;
        lat = (err_i >= 0) ? err_i + 1 : int'(NUM_SIG) + 1;
        for (int n = 1; n <= lat + 2; n++) begin
            if (poke && n == 1) begin
                chk("busy_ready", 64'(bus.cfg_ready), 64'd0);
                bus.commit    = 1'b1;
                bus.cfg_sig   = SIG_W'(3);
                bus.cfg_pin   = PIN_W'(9);
                bus.cfg_dir   = 1'b1;
                bus.cfg_en    = 1'b1;
                bus.cfg_valid = 1'b1;
            end
            step();
            bus.commit    = 1'b0;
            bus.cfg_valid = 1'b0;
            chk("commit_done", 64'(bus.commit_done), 64'(n == lat && err_i < 0));
            chk("commit_err",  64'(bus.commit_err),  64'(n == lat && err_i >= 0));
            chk("commit_busy", 64'(bus.commit_busy), 64'(n < lat));
            chk("cfg_ready",   64'(bus.cfg_ready),   64'(n >= lat));
            if (n == lat) begin
                if (err_i >= 0) begin
                    a_err_sig = SIG_W'(err_i);
                    a_err_pin = m_pin[err_i];
                end else begin
                    for (int i = 0; i < NUM_SIG; i++) begin
                        a_en[i] = m_en[i]; a_dir[i] = m_dir[i]; a_pin[i] = m_pin[i];
                    end
                    a_oe = oe;
                end
                check_outputs("table");
            end
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_sig   = '0;
        bus.cfg_pin   = '0;
        bus.cfg_dir   = 1'b0;
        bus.cfg_en    = 1'b0;
        bus.commit    = 1'b0;
        model_clear();

        // Power-on reset.
        repeat (2) @(negedge clock);
        check_outputs("por");
        chk("por_ready", 64'(bus.cfg_ready), 64'd0);
        chk("por_done",  64'(bus.commit_done), 64'd0);
        reset = 1'b0;
        step();
        chk("post_por_ready", 64'(bus.cfg_ready), 64'd1);
        chk("post_por_busy",  64'(bus.commit_busy), 64'd0);

        // Populate the active table so the mid-scan reset has something to clear.
        cfg_write(3, 12, 1'b1, 1'b1);
        commit_and_check(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        cfg_write(0, 2, 1'b1, 1'b1);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_outputs("midreset");
        chk("midreset_ready", 64'(bus.cfg_ready),   64'd0);
        chk("midreset_busy",  64'(bus.commit_busy), 64'd0);
        chk("midreset_done",  64'(bus.commit_done), 64'd0);
        chk("midreset_err",   64'(bus.commit_err),  64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rel_ready", 64'(bus.cfg_ready),   64'd1);
            chk("rel_done",  64'(bus.commit_done), 64'd0);
            chk("rel_err",   64'(bus.commit_err),  64'd0);
            chk("rel_busy",  64'(bus.commit_busy), 64'd0);
        end
        check_outputs("released");

        // Clean commit: one output and one input.
        cfg_write(0, 3, 1'b1, 1'b1);
        cfg_write(1, 7, 1'b0, 1'b1);
        commit_and_check(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("t1_oe",   64'(pin_oe),       64'h8);
        chk("t1_en",   64'(sig_en),       64'h3);
        chk("t1_pin0", 64'(sig_pin[4:0]), 64'd3);
        chk("t1_pin1", 64'(sig_pin[9:5]), 64'd7);

        // Input on a driven pin is rejected; active table keeps prior values.
        cfg_write(0, 5, 1'b1, 1'b1);
        cfg_write(2, 5, 1'b0, 1'b1);
        commit_and_check(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("t2_err_sig", 64'(bus.err_sig), 64'd2);
        chk("t2_err_pin", 64'(bus.err_pin), 64'd5);
        chk("t2_oe",      64'(pin_oe),      64'h8);

        // Input fan-out is legal; then an out-of-range pin is rejected.
        cfg_write(2, 0, 1'b0, 1'b0);
        cfg_write(1, 4, 1'b0, 1'b1);
        cfg_write(3, 4, 1'b0, 1'b1);
        commit_and_check(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("t3_oe4", 64'(pin_oe[4]), 64'd0);
        cfg_write(0, 30, 1'b1, 1'b1);
        commit_and_check(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("t3_err_sig", 64'(bus.err_sig), 64'd0);
        chk("t3_err_pin", 64'(bus.err_pin), 64'd30);

        // Same-edge write and commit, with busy-time commit/write ignored.
        cfg_write(0, 0, 1'b0, 1'b0);
        commit_and_check(1'b1, 2, 9, 1'b1, 1'b1, 1'b1);
        chk("t4_oe9", 64'(pin_oe[9]), 64'd1);

        // Random rounds biased toward shared and out-of-range pins.
        for (int r = 0; r < 40; r++) begin
            int nw;
            int pr;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                pr = int'($urandom_range(0, 9));
                cfg_write(int'($urandom_range(0, 3)),
                          (pr < 8) ? pr : int'($urandom_range(26, 31)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
            end
            pr = int'($urandom_range(0, 9));
            commit_and_check(($urandom_range(0, 3) == 0),
                             int'($urandom_range(0, 3)),
                             (pr < 8) ? pr : int'($urandom_range(26, 31)),
                             1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) != 0),
                             ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
